// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage: default sizes, register index,
// overflow code and the single-entry pipeline stage record.
package alu_writeback_pkg;

  localparam int DW_DEF    = 8;
  localparam int NREGS_DEF = 8;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
  typedef logic [1:0]                   ovf_t;

  typedef struct packed {
    logic              valid;
    reg_idx_t          dst;
    logic              we;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_regfile.sv
// General register file: one write port, two combinational read ports,
// every entry cleared by the asynchronous reset.
module alu_writeback_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  output logic [DW-1:0]            rdata_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DW-1:0]            rdata_b
);

  logic [DW-1:0] mem_r [NREGS];

  // Storage array: clear on reset, single write per edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// Execute/writeback stage: one pipeline register in front of the register
// file, with operand bypass from that register, latched flags and an
// overflow-event counter.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [$clog2(NREGS)-1:0] IN_DST,
  input  logic                     IN_WE,
  input  logic                     IN_FLAG_WE,
  input  logic [DW-1:0]            ALU_OUT,
  input  logic [1:0]               ALU_OVF,
  input  logic                     ALU_ZF,
  input  logic                     HOLD,
  input  logic [$clog2(NREGS)-1:0] RA_ADDR,
  input  logic [$clog2(NREGS)-1:0] RB_ADDR,
  output logic [DW-1:0]            RA_DATA,
  output logic [DW-1:0]            RB_DATA,
  output logic [1:0]               OVF_Q,
  output logic                     ZF_Q,
  output logic [7:0]               OVF_CNT
);

  wb_entry_t     stage_r;
  ovf_t          ovf_r;
  logic          zf_r;
  logic [7:0]    ovf_cnt_r;
  logic          accept_s;
  logic          commit_s;
  logic          flag_upd_s;
  logic [DW-1:0] rf_a_s;
  logic [DW-1:0] rf_b_s;

  assign IN_READY   = ~HOLD;
  assign accept_s   = IN_VALID & ~HOLD;
  assign commit_s   = stage_r.valid & stage_r.we & ~HOLD;
  assign flag_upd_s = accept_s & IN_FLAG_WE;

  alu_writeback_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .we      (commit_s),
    .waddr   (stage_r.dst),
    .wdata   (stage_r.data),
    .raddr_a (RA_ADDR),
    .rdata_a (rf_a_s),
    .raddr_b (RB_ADDR),
    .rdata_b (rf_b_s)
  );

  // Stage register: load on accept, drain when nothing new arrives, freeze on HOLD
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_r.valid <= 1'b0;
      stage_r.dst   <= {$bits(reg_idx_t){1'b0}};
      stage_r.we    <= 1'b0;
      stage_r.data  <= {DW{1'b0}};
    end else if (accept_s) begin
      stage_r.valid <= 1'b1;
      stage_r.dst   <= IN_DST;
      stage_r.we    <= IN_WE;
      stage_r.data  <= ALU_OUT;
    end else if (!HOLD) begin
      stage_r.valid <= 1'b0;
    end
  end

  // Architectural flags and saturating overflow counter, updated at the accept edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_r     <= 2'b00;
      zf_r      <= 1'b0;
      ovf_cnt_r <= 8'd0;
    end else if (flag_upd_s) begin
      ovf_r <= ALU_OVF;
      zf_r  <= ALU_ZF;
      if ((ALU_OVF != 2'b00) && (ovf_cnt_r != 8'hFF)) begin
        ovf_cnt_r <= ovf_cnt_r + 8'd1;
      end
    end
  end

  // Operand bypass: only from the stage register, never from the live ALU inputs
  always_comb begin
    RA_DATA = rf_a_s;
    RB_DATA = rf_b_s;
    if (stage_r.valid && stage_r.we && (stage_r.dst == RA_ADDR)) begin
      RA_DATA = stage_r.data;
    end else begin
      RA_DATA = rf_a_s;
    end
    if (stage_r.valid && stage_r.we && (stage_r.dst == RB_ADDR)) begin
      RB_DATA = stage_r.data;
    end else begin
      RB_DATA = rf_b_s;
    end
  end

  assign OVF_Q   = ovf_r;
  assign ZF_Q    = zf_r;
  assign OVF_CNT = ovf_cnt_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: bypass timing, HOLD, flags, counter
// saturation and reset behaviour against hand-computed values.
module tb_alu_writeback;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] IN_DST;
  logic       IN_WE;
  logic       IN_FLAG_WE;
  logic [7:0] ALU_OUT;
  logic [1:0] ALU_OVF;
  logic       ALU_ZF;
  logic       HOLD;
  logic [2:0] RA_ADDR;
  logic [2:0] RB_ADDR;
  logic [7:0] RA_DATA;
  logic [7:0] RB_DATA;
  logic [1:0] OVF_Q;
  logic       ZF_Q;
  logic [7:0] OVF_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  alu_writeback dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DST(IN_DST), .IN_WE(IN_WE), .IN_FLAG_WE(IN_FLAG_WE),
    .ALU_OUT(ALU_OUT), .ALU_OVF(ALU_OVF), .ALU_ZF(ALU_ZF), .HOLD(HOLD),
    .RA_ADDR(RA_ADDR), .RB_ADDR(RB_ADDR), .RA_DATA(RA_DATA), .RB_DATA(RB_DATA),
    .OVF_Q(OVF_Q), .ZF_Q(ZF_Q), .OVF_CNT(OVF_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic we, input logic fwe,
                       input logic [7:0] o, input logic [1:0] ov, input logic z);
    IN_VALID   = v;
    IN_DST     = d;
    IN_WE      = we;
    IN_FLAG_WE = fwe;
    ALU_OUT    = o;
    ALU_OVF    = ov;
    ALU_ZF     = z;
  endtask

  initial begin
    RST_N = 1'b0;
    HOLD  = 1'b0;
    RA_ADDR = 3'd0;
    RB_ADDR = 3'd0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    #12;
    check("rst_ready", IN_READY, 1);
    check("rst_ra", RA_DATA, 8'h00);
    check("rst_flags", {OVF_Q, ZF_Q}, 3'b000);
    check("rst_cnt", OVF_CNT, 8'd0);
    RST_N = 1'b1;
    tick();

    // back-to-back dependency
    RA_ADDR = 3'd1;
    RB_ADDR = 3'd2;
    drive(1'b1, 3'd1, 1'b1, 1'b0, 8'd30, 2'b00, 1'b0);
    tick();
    check("b2b_ra_bypass", RA_DATA, 8'd30);
    drive(1'b1, 3'd2, 1'b1, 1'b0, 8'd7, 2'b00, 1'b0);
    tick();
    check("b2b_ra_array", RA_DATA, 8'd30);
    check("b2b_rb_bypass", RB_DATA, 8'd7);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    tick();
    check("b2b_rb_array", RB_DATA, 8'd7);

    // same-destination overwrite
    RA_ADDR = 3'd4;
    drive(1'b1, 3'd4, 1'b1, 1'b0, 8'hAA, 2'b00, 1'b0);
    tick();
    check("ovw_first", RA_DATA, 8'hAA);
    drive(1'b1, 3'd4, 1'b1, 1'b0, 8'h0F, 2'b00, 1'b0);
    tick();
    check("ovw_second", RA_DATA, 8'h0F);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    tick();
    check("ovw_commit", RA_DATA, 8'h0F);
    tick();
    check("ovw_stable", RA_DATA, 8'h0F);

    // HOLD freezes everything; attempted accepts carry flag updates that must be ignored
    RA_ADDR = 3'd5;
    drive(1'b1, 3'd5, 1'b1, 1'b0, 8'h11, 2'b00, 1'b0);
    tick();
    HOLD = 1'b1;
    drive(1'b1, 3'd5, 1'b1, 1'b1, 8'h99, 2'b11, 1'b1);
    #1;
    check("hold_ready", IN_READY, 0);
    check("hold_ra", RA_DATA, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready_loop", IN_READY, 0);
      check("hold_ra_loop", RA_DATA, 8'h11);
    end
    check("hold_flags", {OVF_Q, ZF_Q}, 3'b000);
    check("hold_cnt", OVF_CNT, 8'd0);
    HOLD = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    tick();
    check("hold_release_ready", IN_READY, 1);
    check("hold_commit", RA_DATA, 8'h11);
    tick();
    check("hold_commit_stable", RA_DATA, 8'h11);

    // flags and counter, writing register 0
    RA_ADDR = 3'd0;
    drive(1'b1, 3'd0, 1'b1, 1'b1, 8'h01, 2'b01, 1'b0);
    tick();
    check("flag1_ovf", OVF_Q, 2'b01);
    check("flag1_zf", ZF_Q, 0);
    check("flag1_cnt", OVF_CNT, 8'd1);
    drive(1'b1, 3'd0, 1'b1, 1'b1, 8'h00, 2'b01, 1'b1);
    tick();
    check("flag2_zf", ZF_Q, 1);
    check("flag2_cnt", OVF_CNT, 8'd2);
    drive(1'b1, 3'd0, 1'b1, 1'b0, 8'h05, 2'b10, 1'b0);
    tick();
    check("flag3_unchanged", {OVF_Q, ZF_Q}, 3'b011);
    check("flag3_cnt", OVF_CNT, 8'd2);
    drive(1'b1, 3'd0, 1'b1, 1'b1, 8'h3C, 2'b00, 1'b0);
    tick();
    check("flag4_ovf_clear", {OVF_Q, ZF_Q}, 3'b000);
    check("flag4_cnt", OVF_CNT, 8'd2);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    tick();
    check("reg0_write", RA_DATA, 8'h3C);

    // reset mid-operation discards the pending entry and clears state
    RA_ADDR = 3'd6;
    RB_ADDR = 3'd4;
    drive(1'b1, 3'd6, 1'b1, 1'b1, 8'h77, 2'b11, 1'b1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    check("pre_rst_bypass", RA_DATA, 8'h77);
    RST_N = 1'b0;
    #2;
    check("mid_rst_ra", RA_DATA, 8'h00);
    check("mid_rst_rb", RB_DATA, 8'h00);
    check("mid_rst_flags", {OVF_Q, ZF_Q}, 3'b000);
    check("mid_rst_cnt", OVF_CNT, 8'd0);
    #2;
    RST_N = 1'b1;
    tick();
    check("rst_discard", RA_DATA, 8'h00);
    RA_ADDR = 3'd3;
    drive(1'b1, 3'd3, 1'b1, 1'b0, 8'h55, 2'b00, 1'b0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    tick();
    check("reg3_written", RA_DATA, 8'h55);
    RST_N = 1'b0;
    #2;
    check("reg3_cleared", RA_DATA, 8'h00);
    #2;
    RST_N = 1'b1;
    tick();

    // saturation; IN_WE=0 entries must not bypass
    RA_ADDR = 3'd4;
    drive(1'b1, 3'd4, 1'b0, 1'b1, 8'hFF, 2'b11, 1'b0);
    for (int i = 0; i < 260; i++) begin
      tick();
      if (i == 0) check("nowe_no_bypass", RA_DATA, 8'h00);
      if (i == 253) check("sat_254", OVF_CNT, 8'd254);
      if (i == 254) check("sat_255", OVF_CNT, 8'd255);
    end
    check("sat_hold", OVF_CNT, 8'd255);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    tick();
    check("nowe_no_write", RA_DATA, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
